// File: rtl/core_sequencer_if.sv
// Control bundle between core_sequencer and the mriscvcore datapath.
// master: the sequencer, which drives enables and strobes.
// slave: the datapath, which returns status and class information.
interface core_sequencer_if;
    logic [2:0] iclass;
    logic       mem_done;
    logic       mem_aligned;
    logic       mult_busy;
    logic       irq_req;
    logic       irq_en;
    logic       mem_en;
    logic       mem_wr;
    logic       mem_fetch;
    logic       dec_en;
    logic       alu_en;
    logic       mult_en;
    logic       util_en;
    logic       rd_we;
    logic       pc_inc;
    logic       pc_load;
    logic [1:0] pc_sel;
    logic       savepc;
    logic       err;
    logic [1:0] err_code;
    logic [2:0] state_o;

    modport master (
        input  iclass, mem_done, mem_aligned, mult_busy, irq_req, irq_en,
        output mem_en, mem_wr, mem_fetch, dec_en, alu_en, mult_en, util_en,
               rd_we, pc_inc, pc_load, pc_sel, savepc, err, err_code, state_o
    );

    modport slave (
        output iclass, mem_done, mem_aligned, mult_busy, irq_req, irq_en,
        input  mem_en, mem_wr, mem_fetch, dec_en, alu_en, mult_en, util_en,
               rd_we, pc_inc, pc_load, pc_sel, savepc, err, err_code, state_o
    );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: central control FSM of the mriscvcore datapath.
// Sequences FETCH -> DECODE -> EXEC -> [WAIT] -> WB, starts one execution
// unit per instruction, takes interrupts at WB and traps on faults.
// Every output is registered: the next-state logic also computes the
// outputs belonging to the state being entered, so each strobe is high
// exactly during the cycle its state is current.
// Optional feature: define SEQ_TIMEOUT_EN to build the FETCH/WAIT watchdog.
module core_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    core_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        st_reset  = 3'd0,
        st_fetch  = 3'd1,
        st_decode = 3'd2,
        st_exec   = 3'd3,
        st_wait   = 3'd4,
        st_wb     = 3'd5,
        st_irq    = 3'd6,
        st_trap   = 3'd7
    } state_t;

    localparam logic [2:0] cls_alu   = 3'd0;
    localparam logic [2:0] cls_load  = 3'd1;
    localparam logic [2:0] cls_store = 3'd2;
    localparam logic [2:0] cls_mult  = 3'd3;
    localparam logic [2:0] cls_util  = 3'd4;
    localparam logic [2:0] cls_iret  = 3'd5;

    if (TIMEOUT >= (1 << TO_W)) begin : g_cfg_check
        $error("core_sequencer: TIMEOUT does not fit in TO_W bits");
    end

    state_t     state_r, state_s;
    logic [2:0] cls_r, cls_s;
    logic       first_r, first_s;
    logic [1:0] code_s;
    logic       timeout_s;

    logic mem_en_r, mem_wr_r, mem_fetch_r, dec_en_r, alu_en_r, mult_en_r;
    logic util_en_r, rd_we_r, pc_inc_r, pc_load_r, savepc_r, err_r;
    logic [1:0] pc_sel_r, err_code_r;
    logic mem_en_s, mem_wr_s, mem_fetch_s, dec_en_s, alu_en_s, mult_en_s;
    logic util_en_s, rd_we_s, pc_inc_s, pc_load_s, savepc_s, err_s;
    logic [1:0] pc_sel_s, err_code_s;

`ifdef SEQ_TIMEOUT_EN
    logic [TO_W-1:0] wd_r;

    // Watchdog: counts cycles spent in FETCH/WAIT, cleared on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_r <= {TO_W{1'b0}};
        end else if (state_s != state_r) begin
            wd_r <= {TO_W{1'b0}};
        end else if ((state_r == st_fetch) || (state_r == st_wait)) begin
            wd_r <= wd_r + TO_W'(1);
        end else begin
            wd_r <= {TO_W{1'b0}};
        end
    end

    assign timeout_s = ((state_r == st_fetch) || (state_r == st_wait)) &&
                       (wd_r >= TO_W'(TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state decision, then the registered outputs of the state being entered.
    always_comb begin
        state_s     = state_r;
        cls_s       = cls_r;
        code_s      = 2'd0;
        first_s     = 1'b0;
        mem_en_s    = 1'b0;
        mem_wr_s    = 1'b0;
        mem_fetch_s = 1'b0;
        dec_en_s    = 1'b0;
        alu_en_s    = 1'b0;
        mult_en_s   = 1'b0;
        util_en_s   = 1'b0;
        rd_we_s     = 1'b0;
        pc_inc_s    = 1'b0;
        pc_load_s   = 1'b0;
        savepc_s    = 1'b0;
        err_s       = 1'b0;
        pc_sel_s    = 2'd0;
        err_code_s  = err_code_r;

        case (state_r)
            st_reset: state_s = st_fetch;
            st_fetch: begin
                if (bus.mem_done) begin
                    if (bus.mem_aligned) begin
                        state_s = st_decode;
                    end else begin
                        state_s = st_trap;
                        code_s  = 2'd2;
                    end
                end else if (timeout_s) begin
                    state_s = st_trap;
                    code_s  = 2'd3;
                end else begin
                    state_s = st_fetch;
                end
            end
            st_decode: begin
                cls_s = bus.iclass;
                if (bus.iclass > cls_iret) begin
                    state_s = st_trap;
                    code_s  = 2'd1;
                end else begin
                    state_s = st_exec;
                end
            end
            st_exec: begin
                if ((cls_r == cls_load) || (cls_r == cls_store) || (cls_r == cls_mult)) begin
                    state_s = st_wait;
                end else begin
                    state_s = st_wb;
                end
            end
            st_wait: begin
                if (cls_r == cls_mult) begin
                    // busy may not have risen yet on the first WAIT cycle
                    if (!first_r && !bus.mult_busy) begin
                        state_s = st_wb;
                    end else if (timeout_s) begin
                        state_s = st_trap;
                        code_s  = 2'd3;
                    end else begin
                        state_s = st_wait;
                    end
                end else if (bus.mem_done) begin
                    if (bus.mem_aligned) begin
                        state_s = st_wb;
                    end else begin
                        state_s = st_trap;
                        code_s  = 2'd2;
                    end
                end else if (timeout_s) begin
                    state_s = st_trap;
                    code_s  = 2'd3;
                end else begin
                    state_s = st_wait;
                end
            end
            st_wb: begin
                if (bus.irq_req && bus.irq_en) begin
                    state_s = st_irq;
                end else begin
                    state_s = st_fetch;
                end
            end
            st_irq:  state_s = st_fetch;
            st_trap: state_s = st_fetch;
            default: state_s = st_reset;
        endcase

        case (state_s)
            st_fetch: begin
                mem_en_s    = 1'b1;
                mem_fetch_s = 1'b1;
            end
            st_decode: dec_en_s = 1'b1;
            st_exec: begin
                alu_en_s  = (cls_s == cls_alu);
                mult_en_s = (cls_s == cls_mult);
                util_en_s = (cls_s == cls_util);
            end
            st_wait: begin
                first_s  = (state_r == st_exec);
                mem_en_s = (cls_s == cls_load) || (cls_s == cls_store);
                mem_wr_s = (cls_s == cls_store);
            end
            st_wb: begin
                rd_we_s   = (cls_s == cls_alu) || (cls_s == cls_load) ||
                            (cls_s == cls_mult) || (cls_s == cls_util);
                pc_load_s = (cls_s == cls_util) || (cls_s == cls_iret);
                pc_inc_s  = !((cls_s == cls_util) || (cls_s == cls_iret));
            end
            st_irq: begin
                savepc_s  = 1'b1;
                pc_load_s = 1'b1;
                pc_sel_s  = 2'd1;
            end
            st_trap: begin
                err_s      = 1'b1;
                pc_load_s  = 1'b1;
                pc_sel_s   = 2'd2;
                err_code_s = code_s;
            end
            default: begin
                mem_en_s = 1'b0;
            end
        endcase
    end

    // State, latched class and every output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= st_reset;
            cls_r       <= 3'd0;
            first_r     <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_fetch_r <= 1'b0;
            dec_en_r    <= 1'b0;
            alu_en_r    <= 1'b0;
            mult_en_r   <= 1'b0;
            util_en_r   <= 1'b0;
            rd_we_r     <= 1'b0;
            pc_inc_r    <= 1'b0;
            pc_load_r   <= 1'b0;
            savepc_r    <= 1'b0;
            err_r       <= 1'b0;
            pc_sel_r    <= 2'd0;
            err_code_r  <= 2'd0;
        end else begin
            state_r     <= state_s;
            cls_r       <= cls_s;
            first_r     <= first_s;
            mem_en_r    <= mem_en_s;
            mem_wr_r    <= mem_wr_s;
            mem_fetch_r <= mem_fetch_s;
            dec_en_r    <= dec_en_s;
            alu_en_r    <= alu_en_s;
            mult_en_r   <= mult_en_s;
            util_en_r   <= util_en_s;
            rd_we_r     <= rd_we_s;
            pc_inc_r    <= pc_inc_s;
            pc_load_r   <= pc_load_s;
            savepc_r    <= savepc_s;
            err_r       <= err_s;
            pc_sel_r    <= pc_sel_s;
            err_code_r  <= err_code_s;
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.mem_fetch = mem_fetch_r;
    assign bus.dec_en    = dec_en_r;
    assign bus.alu_en    = alu_en_r;
    assign bus.mult_en   = mult_en_r;
    assign bus.util_en   = util_en_r;
    assign bus.rd_we     = rd_we_r;
    assign bus.pc_inc    = pc_inc_r;
    assign bus.pc_load   = pc_load_r;
    assign bus.pc_sel    = pc_sel_r;
    assign bus.savepc    = savepc_r;
    assign bus.err       = err_r;
    assign bus.err_code  = err_code_r;
    assign bus.state_o   = state_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Table-driven bench for core_sequencer: each record gives the inputs held
// during one cycle and the state/outputs expected just after that edge.
module tb_core_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    core_sequencer_if bus ();

    core_sequencer #(.TIMEOUT(8), .TO_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // output bit map: mem_en mem_wr mem_fetch dec_en alu_en mult_en util_en
    // rd_we pc_inc pc_load savepc err pc_sel[1:0] err_code[1:0]
    localparam logic [15:0] MEM  = 16'h8000;
    localparam logic [15:0] WR   = 16'h4000;
    localparam logic [15:0] F    = 16'hA000;
    localparam logic [15:0] DEC  = 16'h1000;
    localparam logic [15:0] ALU  = 16'h0800;
    localparam logic [15:0] MUL  = 16'h0400;
    localparam logic [15:0] UTL  = 16'h0200;
    localparam logic [15:0] RDWE = 16'h0100;
    localparam logic [15:0] INC  = 16'h0080;
    localparam logic [15:0] LD   = 16'h0040;
    localparam logic [15:0] SAVE = 16'h0020;
    localparam logic [15:0] ERR  = 16'h0010;
    localparam logic [15:0] SEL1 = 16'h0004;
    localparam logic [15:0] SEL2 = 16'h0008;
    localparam logic [15:0] TRP  = ERR | LD | SEL2;

    typedef struct {
        logic       r;
        logic [2:0] c;
        logic       d;
        logic       a;
        logic       b;
        logic       q;
        logic       e;
        logic [2:0] s;
        logic [15:0] o;
    } vec_t;

    vec_t vq[$];
    int   n_chk = 0;
    int   n_err = 0;

    logic [15:0] act;
    assign act = {bus.mem_en, bus.mem_wr, bus.mem_fetch, bus.dec_en, bus.alu_en,
                  bus.mult_en, bus.util_en, bus.rd_we, bus.pc_inc, bus.pc_load,
                  bus.savepc, bus.err, bus.pc_sel, bus.err_code};

    task automatic add(input logic r, input logic [2:0] c, input logic d,
                       input logic a, input logic b, input logic q, input logic e,
                       input logic [2:0] s, input logic [15:0] o);
        vec_t v;
        v.r = r; v.c = c; v.d = d; v.a = a; v.b = b; v.q = q; v.e = e;
        v.s = s; v.o = o;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [2:0] c, input logic d,
                         input logic a, input logic b, input logic q, input logic e);
        rst             = r;
        bus.iclass      = c;
        bus.mem_done    = d;
        bus.mem_aligned = a;
        bus.mult_busy   = b;
        bus.irq_req     = q;
        bus.irq_en      = e;
    endtask

    task automatic chk(input string nm, input logic [2:0] es, input logic [15:0] eo);
        n_chk++;
        if (bus.state_o !== es || act !== eo) begin
            n_err++;
            $display("FAIL %s: got state=%0d out=%h, expected state=%0d out=%h",
                     nm, bus.state_o, act, es, eo);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset, then RESET -> FETCH
        add(1,0,0,0,0,0,0, 3'd0, 16'h0000);
        add(1,0,0,0,0,0,0, 3'd0, 16'h0000);
        add(0,0,0,0,0,0,0, 3'd1, F);
        // ALU, L=2
        add(0,0,0,0,0,0,0, 3'd1, F);
        add(0,0,1,1,0,0,0, 3'd2, DEC);
        add(0,0,0,0,0,0,0, 3'd3, ALU);
        add(0,0,0,0,0,0,0, 3'd5, RDWE | INC);
        add(0,0,0,0,0,0,0, 3'd1, F);
        // UTIL, L=1
        add(0,4,1,1,0,0,0, 3'd2, DEC);
        add(0,4,0,0,0,0,0, 3'd3, UTL);
        add(0,4,0,0,0,0,0, 3'd5, RDWE | LD);
        add(0,4,0,0,0,0,0, 3'd1, F);
        // IRET, L=1
        add(0,5,1,1,0,0,0, 3'd2, DEC);
        add(0,5,0,0,0,0,0, 3'd3, 16'h0000);
        add(0,5,0,0,0,0,0, 3'd5, LD);
        add(0,5,0,0,0,0,0, 3'd1, F);
        // LOAD, L=3
        add(0,1,0,0,0,0,0, 3'd1, F);
        add(0,1,0,0,0,0,0, 3'd1, F);
        add(0,1,1,1,0,0,0, 3'd2, DEC);
        add(0,1,0,0,0,0,0, 3'd3, 16'h0000);
        add(0,1,0,0,0,0,0, 3'd4, MEM);
        add(0,1,0,0,0,0,0, 3'd4, MEM);
        add(0,1,0,0,0,0,0, 3'd4, MEM);
        add(0,1,1,1,0,0,0, 3'd5, RDWE | INC);
        add(0,1,0,0,0,0,0, 3'd1, F);
        // STORE, L=3
        add(0,2,0,0,0,0,0, 3'd1, F);
        add(0,2,0,0,0,0,0, 3'd1, F);
        add(0,2,1,1,0,0,0, 3'd2, DEC);
        add(0,2,0,0,0,0,0, 3'd3, 16'h0000);
        add(0,2,0,0,0,0,0, 3'd4, MEM | WR);
        add(0,2,0,0,0,0,0, 3'd4, MEM | WR);
        add(0,2,0,0,0,0,0, 3'd4, MEM | WR);
        add(0,2,1,1,0,0,0, 3'd5, INC);
        add(0,2,0,0,0,0,0, 3'd1, F);
        // MULT, busy high for 5 WAIT cycles
        add(0,3,1,1,0,0,0, 3'd2, DEC);
        add(0,3,0,0,0,0,0, 3'd3, MUL);
        add(0,3,0,0,0,0,0, 3'd4, 16'h0000);
        add(0,3,0,0,1,0,0, 3'd4, 16'h0000);
        add(0,3,0,0,1,0,0, 3'd4, 16'h0000);
        add(0,3,0,0,1,0,0, 3'd4, 16'h0000);
        add(0,3,0,0,1,0,0, 3'd4, 16'h0000);
        add(0,3,0,0,1,0,0, 3'd4, 16'h0000);
        add(0,3,0,0,0,0,0, 3'd5, RDWE | INC);
        add(0,3,0,0,0,0,0, 3'd1, F);
        // MULT, busy low on first WAIT cycle is ignored
        add(0,3,1,1,0,0,0, 3'd2, DEC);
        add(0,3,0,0,0,0,0, 3'd3, MUL);
        add(0,3,0,0,0,0,0, 3'd4, 16'h0000);
        add(0,3,0,0,0,0,0, 3'd4, 16'h0000);
        add(0,3,0,0,0,0,0, 3'd5, RDWE | INC);
        add(0,3,0,0,0,0,0, 3'd1, F);
        // ALU with irq pending and enabled: only WB reacts
        add(0,0,0,0,0,1,1, 3'd1, F);
        add(0,0,1,1,0,1,1, 3'd2, DEC);
        add(0,0,0,0,0,1,1, 3'd3, ALU);
        add(0,0,0,0,0,1,1, 3'd5, RDWE | INC);
        add(0,0,0,0,0,1,1, 3'd6, SAVE | LD | SEL1);
        add(0,0,0,0,0,0,0, 3'd1, F);
        // ALU with irq pending but disabled
        add(0,0,1,1,0,1,0, 3'd2, DEC);
        add(0,0,0,0,0,1,0, 3'd3, ALU);
        add(0,0,0,0,0,1,0, 3'd5, RDWE | INC);
        add(0,0,0,0,0,1,0, 3'd1, F);
        // illegal class 7
        add(0,7,1,1,0,0,0, 3'd2, DEC);
        add(0,7,0,0,0,0,0, 3'd7, TRP | 16'd1);
        add(0,7,0,0,0,0,0, 3'd1, F | 16'd1);
        // misaligned fetch
        add(0,0,1,0,0,0,0, 3'd7, TRP | 16'd2);
        add(0,0,0,0,0,0,0, 3'd1, F | 16'd2);
        // illegal class 6
        add(0,6,1,1,0,0,0, 3'd2, DEC | 16'd2);
        add(0,6,0,0,0,0,0, 3'd7, TRP | 16'd1);
        add(0,6,0,0,0,0,0, 3'd1, F | 16'd1);
        // misaligned load with irq pending: trap wins, no rd_we
        add(0,1,1,1,0,1,1, 3'd2, DEC | 16'd1);
        add(0,1,0,0,0,1,1, 3'd3, 16'd1);
        add(0,1,0,0,0,1,1, 3'd4, MEM | 16'd1);
        add(0,1,1,0,0,1,1, 3'd7, TRP | 16'd2);
        add(0,1,0,0,0,1,1, 3'd1, F | 16'd2);
        // err_code held through a normal ALU instruction
        add(0,0,1,1,0,0,0, 3'd2, DEC | 16'd2);
        add(0,0,0,0,0,0,0, 3'd3, ALU | 16'd2);
        add(0,0,0,0,0,0,0, 3'd5, RDWE | INC | 16'd2);
        add(0,0,0,0,0,0,0, 3'd1, F | 16'd2);
        // reset in the middle of a load transfer; late mem_done ignored
        add(0,1,1,1,0,0,0, 3'd2, DEC | 16'd2);
        add(0,1,0,0,0,0,0, 3'd3, 16'd2);
        add(0,1,0,0,0,0,0, 3'd4, MEM | 16'd2);
        add(1,1,1,1,0,0,0, 3'd0, 16'h0000);
        add(0,1,1,1,0,0,0, 3'd1, F);
        add(0,1,0,0,0,0,0, 3'd1, F);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].r, vq[i].c, vq[i].d, vq[i].a, vq[i].b, vq[i].q, vq[i].e);
            tick();
            chk($sformatf("vec%0d", i), vq[i].s, vq[i].o);
        end

        // fresh reset so the FETCH dwell starts from a clean entry
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst_again", 3'd0, 16'h0000);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fetch_entry", 3'd1, F);
`ifdef SEQ_TIMEOUT_EN
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk($sformatf("wd_fetch%0d", k), 3'd1, F);
        end
        tick();
        chk("wd_trap", 3'd7, TRP | 16'd3);
        tick();
        chk("wd_refetch", 3'd1, F | 16'd3);
`else
        for (int k = 2; k <= 30; k++) begin
            tick();
            chk($sformatf("nowd_fetch%0d", k), 3'd1, F);
        end
        drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("nowd_decode", 3'd2, DEC);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
